// File: rtl/aes_round_sequencer_if.sv
// ---------------------------------------------------------------------------
// aes_round_sequencer_if
//   Bundles every non-clock signal of the iterative AES-128 round sequencer:
//   the producer handshake, the consumer handshake, and the link to the
//   shared combinational round core.
//
//   Producer side : in_valid, in_ready, datain[127:0], key[127:0]
//   Consumer side : out_valid, out_ready, dataout[127:0], busy
//   Core side     : core_rc[CW-1:0], core_last, core_data[127:0],
//                   core_key[127:0], core_rndout[127:0], core_keyout[127:0]
//
//   slave  : view taken by the sequencer itself
//   master : view taken by the surrounding environment (source, sink, core)
// ---------------------------------------------------------------------------
interface aes_round_sequencer_if #(
  parameter int CW = 4
);

  logic          in_valid;
  logic          in_ready;
  logic [127:0]  datain;
  logic [127:0]  key;

  logic          out_valid;
  logic          out_ready;
  logic [127:0]  dataout;
  logic          busy;

  logic [CW-1:0] core_rc;
  logic          core_last;
  logic [127:0]  core_data;
  logic [127:0]  core_key;
  logic [127:0]  core_rndout;
  logic [127:0]  core_keyout;

  modport slave (
    input  in_valid, datain, key, out_ready, core_rndout, core_keyout,
    output in_ready, out_valid, dataout, busy,
           core_rc, core_last, core_data, core_key
  );

  modport master (
    output in_valid, datain, key, out_ready, core_rndout, core_keyout,
    input  in_ready, out_valid, dataout, busy,
           core_rc, core_last, core_data, core_key
  );

endinterface

// File: rtl/aes_round_sequencer.sv
// ---------------------------------------------------------------------------
// aes_round_sequencer
//   Iterative AES-128 encryption controller. One combinational round core is
//   reused for all ten rounds: the sequencer holds the cipher state and the
//   current round key in registers, feeds them to the core together with the
//   round index, and captures the core's result on every clock edge until the
//   final round has been applied. The ciphertext is then presented on a
//   valid/ready handshake and held until the consumer takes it.
//
//   Ports:
//     clk    : single clock, all state updates on the rising edge
//     rst_n  : asynchronous, active-low reset
//     i_bus  : aes_round_sequencer_if.slave
//              producer  -> in_valid, datain, key / in_ready
//              consumer  -> out_ready / out_valid, dataout, busy
//              round core-> core_rndout, core_keyout /
//                           core_rc, core_last, core_data, core_key
//
//   Timing: a block accepted on edge T produces out_valid after edge T+10.
//   With out_ready held high a new block can be accepted on the very edge
//   that retires the previous result, giving one block every 11 cycles.
// ---------------------------------------------------------------------------
module aes_round_sequencer #(
  parameter int ROUNDS = 10,
  parameter int CW     = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  aes_round_sequencer_if.slave    i_bus
);

  // Index of the final round; the core skips MixColumns when it sees it.
  localparam logic [CW-1:0] LastRnd = CW'(ROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_nextState;

  logic [127:0]  r_stateReg;
  logic [127:0]  r_keyReg;
  logic [127:0]  r_dataout;
  logic [CW-1:0] r_rndCnt;
  logic          r_outValid;

  logic          w_inReady;
  logic          w_busy;
  logic          w_accept;
  logic          w_lastRnd;

  assign w_lastRnd = (r_rndCnt == LastRnd);
  assign w_accept  = i_bus.in_valid & w_inReady;

  // Next-state and handshake decode. DONE can hand straight over to ROUND
  // when the result is taken on the same edge a new block arrives, so the
  // pipeline never inserts an idle bubble between back-to-back blocks.
  always_comb begin
    w_nextState = r_state;
    w_inReady   = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      IDLE: begin
        w_inReady = 1'b1;
        if (i_bus.in_valid) begin
          w_nextState = ROUND;
        end
      end
      ROUND: begin
        w_busy = 1'b1;
        if (w_lastRnd) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        if (i_bus.out_ready) begin
          w_inReady   = 1'b1;
          w_nextState = i_bus.in_valid ? ROUND : IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Datapath registers. An accepted block is loaded with the round-0
  // AddRoundKey already applied, so the core only ever sees rounds 1..10.
  // The counter is cleared on the final round and therefore never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stateReg <= '0;
      r_keyReg   <= '0;
      r_dataout  <= '0;
      r_rndCnt   <= '0;
      r_outValid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_stateReg <= i_bus.datain ^ i_bus.key;
        r_keyReg   <= i_bus.key;
        r_rndCnt   <= '0;
      end else if (r_state == ROUND) begin
        r_stateReg <= i_bus.core_rndout;
        r_keyReg   <= i_bus.core_keyout;
        if (w_lastRnd) begin
          r_rndCnt   <= '0;
          r_dataout  <= i_bus.core_rndout;
          r_outValid <= 1'b1;
        end else begin
          r_rndCnt <= r_rndCnt + CW'(1);
        end
      end

      // Result leaves on the handshake; dataout keeps its last value.
      if ((r_state == DONE) && i_bus.out_ready) begin
        r_outValid <= 1'b0;
      end
    end
  end

  // The core sees registers only, never the producer inputs directly.
  assign i_bus.in_ready  = w_inReady;
  assign i_bus.busy      = w_busy;
  assign i_bus.out_valid = r_outValid;
  assign i_bus.dataout   = r_dataout;
  assign i_bus.core_rc   = r_rndCnt;
  assign i_bus.core_last = w_lastRnd;
  assign i_bus.core_data = r_stateReg;
  assign i_bus.core_key  = r_keyReg;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// ---------------------------------------------------------------------------
// tb_aes_round_sequencer
//   Drives the AES-128 round sequencer with a behavioural round core attached
//   and compares its ciphertexts and handshake timing against known-answer
//   vectors.
// ---------------------------------------------------------------------------
module tb_aes_round_sequencer;

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  aes_round_sequencer_if #(.CW(4)) bus ();

  aes_round_sequencer #(
    .ROUNDS(10),
    .CW    (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .i_bus (bus.slave)
  );

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  localparam logic [127:0] C1Key = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1Pt  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1Ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] BKey  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] BPt   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] BCt   = 128'h3925841d02dc09fbdc118597196a0b32;

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural AES round core: GF(2^8) arithmetic and S-box derived
  // from the field inverse plus affine transform.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r, p, b;
    r = 8'h01;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) r = gmul(r, p);
      p = gmul(p, p);
    end
    b = r;
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] keyStep(input logic [127:0] k, input logic [3:0] rc);
    logic [31:0] w3, rot, sub, tmp, n0, n1, n2, n3;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < int'(rc); i++) begin
      rcon = gmul(rcon, 8'h02);
    end
    w3  = k[31:0];
    rot = {w3[23:0], w3[31:24]};
    sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    tmp = sub ^ {rcon, 24'h000000};
    n0  = k[127:96] ^ tmp;
    n1  = k[95:64]  ^ n0;
    n2  = k[63:32]  ^ n1;
    n3  = k[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] aesRound(input logic [127:0] st, input logic [127:0] rk,
                                            input logic last);
    logic [127:0] s, t, m;
    logic [7:0]   a0, a1, a2, a3;
    for (int b = 0; b < 16; b++) begin
      s[127 - 8*b -: 8] = sbox(st[127 - 8*b -: 8]);
    end
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        t[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + r) % 4)) -: 8];
      end
    end
    m = t;
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[127 - 8*(4*c + 0) -: 8];
        a1 = t[127 - 8*(4*c + 1) -: 8];
        a2 = t[127 - 8*(4*c + 2) -: 8];
        a3 = t[127 - 8*(4*c + 3) -: 8];
        m[127 - 8*(4*c + 0) -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
        m[127 - 8*(4*c + 1) -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
        m[127 - 8*(4*c + 2) -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
        m[127 - 8*(4*c + 3) -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
      end
    end
    return m ^ rk;
  endfunction

  assign bus.core_keyout = keyStep(bus.core_key, bus.core_rc);
  assign bus.core_rndout = aesRound(bus.core_data, keyStep(bus.core_key, bus.core_rc),
                                    bus.core_last);

  // Hard stop in case something upstream never terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
    end
  endtask

  // Presents one block and lets it be taken on the next edge.
  task automatic applyStimulus(input logic [127:0] k, input logic [127:0] pt);
    bus.in_valid = 1'b1;
    bus.datain   = pt;
    bus.key      = k;
    checkOutput("accept_in_ready", 128'(bus.in_ready), 128'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Waits for out_valid with a cycle budget; returns cycles waited.
  task automatic waitOutValid(output int n);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (bus.out_valid !== 1'b1) begin
      checkOutput("out_valid_timeout", 128'(bus.out_valid), 128'd1);
    end
  endtask

  // Full block with out_ready high: round-index sequence, latency,
  // ciphertext and the return to IDLE after the handshake.
  task automatic runBlock(input logic [127:0] k, input logic [127:0] pt,
                          input logic [127:0] ct);
    int seqErr;
    seqErr = 0;
    bus.out_ready = 1'b1;
    applyStimulus(k, pt);
    for (int i = 0; i < 10; i++) begin
      if (bus.core_rc !== 4'(i) || bus.core_last !== (i == 9) ||
          bus.out_valid !== 1'b0 || bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
        seqErr++;
      end
      tick();
    end
    checkOutput("round_sequence_bad_cycles", 128'(seqErr), 128'd0);
    checkOutput("latency_out_valid", 128'(bus.out_valid), 128'd1);
    checkOutput("ciphertext", bus.dataout, ct);
    tick();
    checkOutput("post_handshake_out_valid", 128'(bus.out_valid), 128'd0);
    checkOutput("post_handshake_in_ready", 128'(bus.in_ready), 128'd1);
    checkOutput("post_handshake_dataout_kept", bus.dataout, ct);
  endtask

  initial begin
    vec_t vecs[3];
    int   n;
    int   bad;

    vecs[0] = '{key: C1Key, pt: C1Pt, ct: C1Ct};
    vecs[1] = '{key: BKey,  pt: BPt,  ct: BCt};
    vecs[2] = '{key: 128'h0, pt: 128'h0, ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.datain    = '0;
    bus.key       = '0;
    rst_n         = 1'b0;

    // Reset state with inputs toggling.
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.datain    = {$urandom, $urandom, $urandom, $urandom};
      bus.key       = {$urandom, $urandom, $urandom, $urandom};
      tick();
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.dataout !== 128'h0 ||
          bus.in_ready !== 1'b1 || bus.core_rc !== 4'd0 || bus.core_last !== 1'b0) begin
        bad++;
      end
    end
    checkOutput("reset_hold_bad_cycles", 128'(bad), 128'd0);
    checkOutput("reset_core_data", bus.core_data, 128'h0);
    checkOutput("reset_core_key", bus.core_key, 128'h0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b1;
    tick();
    checkOutput("after_release_in_ready", 128'(bus.in_ready), 128'd1);

    // Known-answer table.
    for (int v = 0; v < 3; v++) begin
      $display("[TB] vector %0d", v);
      runBlock(vecs[v].key, vecs[v].pt, vecs[v].ct);
    end

    // Backpressure: result held for 20 stalled cycles, new blocks refused.
    bus.out_ready = 1'b0;
    applyStimulus(C1Key, C1Pt);
    waitOutValid(n);
    checkOutput("bp_latency", 128'(n), 128'd10);
    bad = 0;
    bus.in_valid = 1'b1;
    bus.datain   = BPt;
    bus.key      = BKey;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid !== 1'b1 || bus.dataout !== C1Ct || bus.in_ready !== 1'b0 ||
          bus.busy !== 1'b0) begin
        bad++;
      end
      tick();
    end
    checkOutput("bp_stall_bad_cycles", 128'(bad), 128'd0);
    checkOutput("bp_dataout", bus.dataout, C1Ct);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    checkOutput("bp_release_out_valid", 128'(bus.out_valid), 128'd0);
    checkOutput("bp_release_idle_in_ready", 128'(bus.in_ready), 128'd1);
    checkOutput("bp_release_busy", 128'(bus.busy), 128'd0);

    // Back-to-back: second block accepted on the first result's handshake.
    bus.out_ready = 1'b1;
    applyStimulus(C1Key, C1Pt);
    bus.in_valid = 1'b1;
    bus.datain   = BPt;
    bus.key      = BKey;
    waitOutValid(n);
    checkOutput("b2b_first_latency", 128'(n), 128'd10);
    checkOutput("b2b_first_ct", bus.dataout, C1Ct);
    checkOutput("b2b_done_in_ready", 128'(bus.in_ready), 128'd1);
    tick();
    bus.in_valid = 1'b0;
    checkOutput("b2b_second_busy", 128'(bus.busy), 128'd1);
    checkOutput("b2b_second_rc", 128'(bus.core_rc), 128'd0);
    checkOutput("b2b_out_valid_dropped", 128'(bus.out_valid), 128'd0);
    waitOutValid(n);
    checkOutput("b2b_result_spacing", 128'(n + 1), 128'd11);
    checkOutput("b2b_second_ct", bus.dataout, BCt);
    tick();
    checkOutput("b2b_idle_in_ready", 128'(bus.in_ready), 128'd1);

    // in_valid during ROUND is ignored.
    applyStimulus(C1Key, C1Pt);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = (i >= 1 && i <= 8);
      bus.datain   = 128'hffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff;
      bus.key      = BKey;
      if (bus.in_ready !== 1'b0 || bus.core_rc !== 4'(i)) bad++;
      tick();
    end
    bus.in_valid = 1'b0;
    checkOutput("busy_ignore_bad_cycles", 128'(bad), 128'd0);
    checkOutput("busy_ignore_out_valid", 128'(bus.out_valid), 128'd1);
    checkOutput("busy_ignore_ct", bus.dataout, C1Ct);
    tick();
    checkOutput("busy_ignore_idle", 128'(bus.busy), 128'd0);

    // Reset in the middle of a block.
    applyStimulus(C1Key, C1Pt);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("midreset_rc_before", 128'(bus.core_rc), 128'd5);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_out_valid", 128'(bus.out_valid), 128'd0);
    checkOutput("midreset_in_ready", 128'(bus.in_ready), 128'd1);
    checkOutput("midreset_rc", 128'(bus.core_rc), 128'd0);
    checkOutput("midreset_busy", 128'(bus.busy), 128'd0);
    checkOutput("midreset_core_data", bus.core_data, 128'h0);
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    checkOutput("midreset_discarded_bad_cycles", 128'(bad), 128'd0);
    runBlock(C1Key, C1Pt, C1Ct);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
